// File: rtl/regfile_dbg_pkg.sv
// Shared definitions for the register-file debug dump path.
// Latency: n/a (types and default sizes only).
// Backpressure: n/a. Sizes are shared with the SR1 ownership mux and the display sequencer.
package regfile_dbg_pkg;

   localparam int NUM_REGS      = 8;
   localparam int ADDR_W        = 3;
   localparam int DATA_W        = 16;
   localparam int SETTLE_CYCLES = 1;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      PRESENT,
      DONE
   } state_t;

endpackage

// File: rtl/reg_16.sv
// 16-bit load-enabled register with synchronous active-high reset.
// Latency: D appears on Data_Out one edge after Load.
// Backpressure: none; Load=0 holds the current value indefinitely.
// Ports: Clk, Reset (sync, active-high), Load (capture strobe), D (input), Data_Out (held value).
module reg_16 (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Load,
   input  logic [15:0] D,
   output logic [15:0] Data_Out
);

   always_ff @(posedge Clk) begin
      if (Reset)
         Data_Out <= 16'h0000;
      else if (Load)
         Data_Out <= D;
   end

endmodule

// File: rtl/regfile_dump.sv
// Walks R0..R(NUM_REGS-1) through the SR1 read port and streams (index, value) beats.
// Latency: SETTLE_CYCLES cycles of select settling per register, then one presented beat.
// Backpressure: a beat is held stable while Out_Ready=0; the walk stalls without limit.
// Ports: Clk/Reset (sync, active-high); Start request; SR_Sel/Reg_Data regfile SR1 port;
//        Out_Data/Out_Idx/Out_Valid/Out_Ready beat stream; Busy, Done pulse, Sum_Out running sum.
module regfile_dump #(
   parameter int NUM_REGS      = regfile_dbg_pkg::NUM_REGS,
   parameter int ADDR_W        = regfile_dbg_pkg::ADDR_W,
   parameter int DATA_W        = regfile_dbg_pkg::DATA_W,
   parameter int SETTLE_CYCLES = regfile_dbg_pkg::SETTLE_CYCLES
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   output logic [ADDR_W-1:0] SR_Sel,
   input  logic [DATA_W-1:0] Reg_Data,
   output logic [DATA_W-1:0] Out_Data,
   output logic [ADDR_W-1:0] Out_Idx,
   output logic              Out_Valid,
   input  logic              Out_Ready,
   output logic              Busy,
   output logic              Done,
   output logic [DATA_W-1:0] Sum_Out
);

   import regfile_dbg_pkg::*;

   localparam int                CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  RELOAD  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(NUM_REGS - 1);

   state_t            state;
   logic [ADDR_W-1:0] idx;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] acc;
   logic              capture;

   // The read mux has had SETTLE_CYCLES cycles to resolve once the counter reaches zero.
   assign capture = (state == SETTLE) && (cnt == '0);

   // idx is forced back to 0 on the way into IDLE, so SR_Sel idles at R0.
   assign SR_Sel = idx;

   reg_16 u_out_data (
      .Clk      (Clk),
      .Reset    (Reset),
      .Load     (capture),
      .D        (Reg_Data),
      .Data_Out (Out_Data)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         idx       <= '0;
         cnt       <= '0;
         acc       <= '0;
         Out_Idx   <= '0;
         Out_Valid <= 1'b0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         Sum_Out   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (Start) begin
                  state <= SETTLE;
                  idx   <= '0;
                  acc   <= '0;
                  cnt   <= RELOAD;
                  Busy  <= 1'b1;
               end
            end

            SETTLE: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  // Out_Data is loaded by the same strobe inside u_out_data.
                  Out_Idx   <= idx;
                  acc       <= acc + Reg_Data;
                  Out_Valid <= 1'b1;
                  state     <= PRESENT;
               end
            end

            PRESENT: begin
               if (Out_Valid && Out_Ready) begin
                  Out_Valid <= 1'b0;
                  if (idx == LAST) begin
                     Sum_Out <= acc;
                     Done    <= 1'b1;
                     state   <= DONE;
                  end else begin
                     idx   <= idx + ADDR_W'(1);
                     cnt   <= RELOAD;
                     state <= SETTLE;
                  end
               end
            end

            DONE: begin
               // Start is deliberately not looked at here.
               Done  <= 1'b0;
               Busy  <= 1'b0;
               idx   <= '0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
